neuron_lanes: RTL and testbench
===============================

# neuron_lanes

Multi-lane, handshaked successor to the single-lane neuron in the MLP datapath. Computes one fully-connected neuron output, act(Σ w·x + b), consuming LANES input activations per beat from a packed bus, with weights held in banked on-chip RAM loaded over the shared config bus. Adds valid/ready backpressure on input and output, an explicit control FSM, a parametrised accumulator width and output requantisation.

## Interface
- LAYER_NO, 0, layer id matched against cfg_layer
- NEURON_NO, 0, neuron id matched against cfg_neuron
- NUM_WEIGHT, 784, weights (inputs) per neuron
- DATA_WIDTH, 16, signed activation/weight/bias width
- FRAC_WIDTH, 8, fractional bits of weights and bias
- LANES, 4, products per beat
- ACC_WIDTH, 2*DATA_WIDTH+8, signed accumulator width
- ACT_TYPE, "relu", "relu" or "none"

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_layer  in  16  config layer id
- cfg_neuron  in  16  config neuron id
- wt_valid  in  1  weight write strobe
- wt_data  in  DATA_WIDTH  weight value
- bias_valid  in  1  bias write strobe
- bias_data  in  DATA_WIDTH  bias value
- cfg_ready  out  1  high only in IDLE; writes outside IDLE dropped
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when both high
- in_data  in  LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream ready
- out_data  out  DATA_WIDTH  activated result
- busy  out  1  state != IDLE

## Operation
- Config write: wt_valid & cfg match & IDLE writes weight wr_ptr to bank wr_ptr%LANES, row wr_ptr/LANES; wr_ptr wraps NUM_WEIGHT-1→0. bias_valid likewise loads bias register. Non-matching ids ignored.
- NUM_BEATS = ceil(NUM_WEIGHT/LANES). Lanes with index beat*LANES+k ≥ NUM_WEIGHT forced to zero product.
- FSM: IDLE →(first beat accepted) ACCUM →(NUM_BEATS accepted) DRAIN →(pipeline empty) BIAS → ACT → OUT →(out_valid&out_ready) IDLE; accumulator and beat counter clear on OUT exit.
- in_ready = (IDLE or ACCUM) and beats accepted < NUM_BEATS (combinational).
- Pipeline per beat: P0 accept, issue RAM read, register in_data; P1 LANES signed multiplies registered (2*DATA_WIDTH); P2 sign-extended lane sum registered (exact); P3 saturating accumulate into ACC_WIDTH.
- BIAS: acc += sign_ext(bias) << FRAC_WIDTH, saturating.
- ACT: r = acc >>> FRAC_WIDTH, clamped to signed DATA_WIDTH; relu maps r<0 to 0; registered into out_data.
- Saturation: positive overflow → max, negative → min, at every accumulate and bias add.

## Timing
- Reset: state IDLE, out_valid 0, out_data 0, busy 0, cfg_ready 1, in_ready 1, wr_ptr 0, beat counter 0, acc 0, bias 0; weight RAM contents not reset.
- RAM read latency 1 cycle.
- out_valid rises 6 cycles after the clock edge accepting the last beat (3 pipeline, BIAS, ACT, OUT); gaps in in_valid only stretch ACCUM.
- out_data/out_valid stable while out_valid & !out_ready; next vector's first beat accepted earliest the cycle after output handshake.
- Reset mid-operation aborts immediately; partial sums discarded.

## Structure
- Package neuron_pkg: ACT_RELU/ACT_NONE constants, saturating-add and clamp functions, NUM_BEATS/bank-row width helpers.
- Sub-module neuron_weight_bank: one simple dual-port RAM (write port, registered read), instantiated LANES times.

## Test plan
Bench params: DATA_WIDTH 16, FRAC_WIDTH 8, LANES 4, NUM_WEIGHT 10 (3 beats).
- Weights all 0x0100, bias 0x0200, inputs all 0x0100 -> out_data 0x0C00, out_valid 6 cycles after third beat.
- Same, third beat lanes 2/3 = 0x7FFF -> still 0x0C00 (masking).
- Weights 0xFF00 -> relu 0x0000; ACT_TYPE "none" 0xF800.
- Weights/inputs/bias 0x7FFF -> 0x7FFF; weights 0x8000, inputs 0x7FFF -> relu 0x0000, "none" 0x8000.
- out_ready low 4 cycles -> out_data held, in_ready 0; after handshake second vector yields 0x0C00 (acc cleared); cfg writes during busy ignored.
- rst_n low after 2 beats -> out_valid 0, in_ready 1, fresh 3-beat vector yields correct result; wt_valid with cfg_neuron mismatch leaves weights unchanged.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the multi-lane neuron: activation selectors,
// FSM states, beat/address sizing and saturating arithmetic.
package neuron_pkg;

    localparam string ACT_RELU = "relu";
    localparam string ACT_NONE = "none";

    localparam int unsigned SAT_W = 64;

    typedef logic signed [SAT_W-1:0] sat_t;
    typedef logic signed [SAT_W:0]   wide_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_BIAS,
        ST_ACT,
        ST_OUT
    } state_e;

    function automatic int unsigned num_beats(input int unsigned nw, input int unsigned lanes);
        return (nw + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    // Clamp x into the signed range of a w-bit value (w <= SAT_W).
    function automatic sat_t clamp_s(input wide_t x, input int unsigned w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -(wide_t'(1) <<< (w - 1));
        if (x > hi) return sat_t'(hi);
        if (x < lo) return sat_t'(lo);
        return sat_t'(x);
    endfunction

    function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned w);
        return clamp_s(wide_t'(a) + wide_t'(b), w);
    endfunction

endpackage

// File: rtl/neuron_lanes_if.sv
// Streaming input-beat and output-result handshakes of the neuron.
interface neuron_lanes_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES*DATA_WIDTH-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/neuron_weight_bank.sv
// One weight bank: simple dual-port RAM with a single-cycle registered read.
module neuron_weight_bank
    import neuron_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 196,
    parameter int unsigned AW         = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [AW-1:0]                waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic                         re,
    input  logic [AW-1:0]                raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] rdata_q;
    logic signed [DATA_WIDTH-1:0] rdata_d;

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/neuron_lanes.sv
// Multi-lane fully-connected neuron: act(sum w*x + b) over LANES products per
// beat, weights in banked RAM, valid/ready on both streams.
module neuron_lanes
    import neuron_pkg::*;
#(
    parameter int unsigned LAYER_NO   = 0,
    parameter int unsigned NEURON_NO  = 0,
    parameter int unsigned NUM_WEIGHT = 784,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_WIDTH = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter string       ACT_TYPE   = ACT_RELU
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           cfg_layer,
    input  logic [15:0]           cfg_neuron,
    input  logic                  wt_valid,
    input  logic [DATA_WIDTH-1:0] wt_data,
    input  logic                  bias_valid,
    input  logic [DATA_WIDTH-1:0] bias_data,
    output logic                  cfg_ready,
    output logic                  busy,
    neuron_lanes_if.slave         bus
);

    localparam int unsigned NUM_BEATS = num_beats(NUM_WEIGHT, LANES);
    localparam int unsigned RW        = addr_width(NUM_BEATS);
    localparam int unsigned PW        = addr_width(NUM_WEIGHT);
    localparam int unsigned BW        = addr_width(NUM_BEATS + 1);
    localparam int unsigned PROD_W    = 2*DATA_WIDTH;
    localparam int unsigned SUM_W     = PROD_W + addr_width(LANES);
    localparam bit          USE_RELU  = (ACT_TYPE == ACT_RELU);

    state_e                        state_q, state_d;
    logic [BW-1:0]                 beat_q, beat_d;
    logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
    logic signed [DATA_WIDTH-1:0]  bias_q, bias_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                          p0_valid_q, p0_valid_d;
    logic [BW-1:0]                 p0_beat_q, p0_beat_d;
    logic [LANES*DATA_WIDTH-1:0]   data_q, data_d;
    logic                          p1_valid_q, p1_valid_d;
    logic signed [PROD_W-1:0]      prod_q [LANES];
    logic signed [PROD_W-1:0]      prod_d [LANES];
    logic                          p2_valid_q, p2_valid_d;
    logic signed [SUM_W-1:0]       sum_q, sum_d;
    logic                          out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
    logic                          busy_q, busy_d;
    logic                          cfg_ready_q, cfg_ready_d;

    logic                          cfg_match;
    logic                          in_ready_c;
    logic                          accept;
    logic                          last_beat;
    logic                          out_fire;
    int unsigned                   wr_lane;
    logic [RW-1:0]                 wr_row;
    logic [LANES-1:0]              bank_we;
    logic signed [DATA_WIDTH-1:0]  bank_rd [LANES];
    logic signed [DATA_WIDTH-1:0]  lane_x  [LANES];
    logic [LANES-1:0]              lane_ok;
    logic signed [DATA_WIDTH-1:0]  act_val;

    assign cfg_match  = (cfg_layer == 16'(LAYER_NO)) && (cfg_neuron == 16'(NEURON_NO))
                        && (state_q == ST_IDLE);
    assign in_ready_c = ((state_q == ST_IDLE) || (state_q == ST_ACCUM)) && (beat_q < BW'(NUM_BEATS));
    assign accept     = bus.in_valid && in_ready_c;
    assign last_beat  = accept && (beat_q == BW'(NUM_BEATS - 1));
    assign out_fire   = (state_q == ST_OUT) && out_valid_q && bus.out_ready;
    assign wr_lane    = 32'(wr_ptr_q) % LANES;
    assign wr_row     = RW'(32'(wr_ptr_q) / LANES);

    always_comb begin
        bank_we = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            bank_we[k] = wt_valid && cfg_match && (wr_lane == k);
        end
    end

    for (genvar gk = 0; gk < LANES; gk++) begin : g_bank
        neuron_weight_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (NUM_BEATS),
            .AW         (RW)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bank_we[gk]),
            .waddr (wr_row),
            .wdata (wt_data),
            .re    (accept),
            .raddr (RW'(beat_q)),
            .rdata (bank_rd[gk])
        );
        assign lane_x[gk]  = data_q[gk*DATA_WIDTH +: DATA_WIDTH];
        // Lanes past the last weight of the final beat contribute nothing.
        assign lane_ok[gk] = (32'(p0_beat_q) * LANES + 32'(gk)) < NUM_WEIGHT;
    end

    // Control FSM and config registers.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wr_ptr_d = wr_ptr_q;
        bias_d   = bias_q;
        if (accept) beat_d = beat_q + BW'(1);
        if (wt_valid && cfg_match) begin
            wr_ptr_d = (wr_ptr_q == PW'(NUM_WEIGHT - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (bias_valid && cfg_match) bias_d = bias_data;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = last_beat ? ST_DRAIN : ST_ACCUM;
            ST_ACCUM: if (last_beat) state_d = ST_DRAIN;
            ST_DRAIN: if (!p0_valid_q && !p1_valid_q && !p2_valid_q) state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_ACT;
            ST_ACT:   state_d = ST_OUT;
            ST_OUT: begin
                if (out_fire) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_OUT);
        busy_d      = (state_d != ST_IDLE);
        cfg_ready_d = (state_d == ST_IDLE);
    end

    // Requantise the accumulator back to DATA_WIDTH and apply the activation.
    always_comb begin
        act_val = DATA_WIDTH'(clamp_s(wide_t'(acc_q) >>> FRAC_WIDTH, DATA_WIDTH));
        if (USE_RELU && act_val[DATA_WIDTH-1]) act_val = '0;
    end

    // Datapath pipeline: P0 capture, P1 multiply, P2 lane sum, P3 accumulate.
    always_comb begin
        p0_valid_d = accept;
        p0_beat_d  = p0_beat_q;
        data_d     = data_q;
        if (accept) begin
            p0_beat_d = beat_q;
            data_d    = bus.in_data;
        end
        p1_valid_d = p0_valid_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            prod_d[k] = prod_q[k];
            if (p0_valid_q) begin
                prod_d[k] = lane_ok[k] ? PROD_W'(lane_x[k]) * PROD_W'(bank_rd[k]) : '0;
            end
        end
        p2_valid_d = p1_valid_q;
        sum_d = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            sum_d = sum_d + SUM_W'(prod_q[k]);
        end
        acc_d = acc_q;
        if (p2_valid_q) begin
            acc_d = ACC_WIDTH'(sat_add(sat_t'(acc_q), sat_t'(sum_q), ACC_WIDTH));
        end else if (state_q == ST_BIAS) begin
            acc_d = ACC_WIDTH'(sat_add(sat_t'(acc_q), sat_t'(bias_q) <<< FRAC_WIDTH, ACC_WIDTH));
        end
        if (out_fire) acc_d = '0;
        out_data_d = (state_q == ST_ACT) ? act_val : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            wr_ptr_q    <= '0;
            bias_q      <= '0;
            acc_q       <= '0;
            p0_valid_q  <= 1'b0;
            p0_beat_q   <= '0;
            data_q      <= '0;
            p1_valid_q  <= 1'b0;
            prod_q      <= '{default: '0};
            p2_valid_q  <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            bias_q      <= bias_d;
            acc_q       <= acc_d;
            p0_valid_q  <= p0_valid_d;
            p0_beat_q   <= p0_beat_d;
            data_q      <= data_d;
            p1_valid_q  <= p1_valid_d;
            prod_q      <= prod_d;
            p2_valid_q  <= p2_valid_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = busy_q;
    assign cfg_ready     = cfg_ready_q;

endmodule

// File: tb/tb_neuron_lanes.sv
// Directed bench: a relu instance and a linear instance share all stimulus;
// each vector checks latency and both activated results.
module tb_neuron_lanes;
    import neuron_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned LN = 4;
    localparam int unsigned NW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]   cfg_layer = '0, cfg_neuron = '0;
    logic          wt_valid = 1'b0, bias_valid = 1'b0;
    logic [DW-1:0] wt_data = '0, bias_data = '0;
    logic          in_valid = 1'b0, out_ready = 1'b1;
    logic [LN*DW-1:0] in_data = '0;
    logic cfg_ready_a, busy_a, cfg_ready_b, busy_b;

    neuron_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) if_a ();
    neuron_lanes_if #(.DATA_WIDTH(DW), .LANES(LN)) if_b ();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_data   = in_data;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_data   = in_data;
    assign if_b.out_ready = out_ready;

    neuron_lanes #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_WIDTH(8), .LANES(LN),
                   .ACT_TYPE(ACT_RELU)) dut_a (
        .clk(clk), .rst_n(rst_n), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .wt_valid(wt_valid), .wt_data(wt_data), .bias_valid(bias_valid), .bias_data(bias_data),
        .cfg_ready(cfg_ready_a), .busy(busy_a), .bus(if_a.slave));

    neuron_lanes #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_WIDTH(8), .LANES(LN),
                   .ACT_TYPE(ACT_NONE)) dut_b (
        .clk(clk), .rst_n(rst_n), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
        .wt_valid(wt_valid), .wt_data(wt_data), .bias_valid(bias_valid), .bias_data(bias_data),
        .cfg_ready(cfg_ready_b), .busy(busy_b), .bus(if_b.slave));

    typedef struct {
        logic [15:0] wt;
        logic [15:0] bias;
        logic [15:0] x;
        logic [15:0] x_hi;
        logic [15:0] exp_relu;
        logic [15:0] exp_none;
    } vec_t;

    vec_t vecs [7];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] wt, input logic [15:0] b);
        wt_valid = 1'b1;
        wt_data  = wt;
        repeat (NW) tick();
        wt_valid   = 1'b0;
        bias_valid = 1'b1;
        bias_data  = b;
        tick();
        bias_valid = 1'b0;
    endtask

    // Lanes 2/3 of the last beat carry x_hi; they lie past weight 9.
    task automatic send_beats(input logic [15:0] x, input logic [15:0] x_hi, input int n);
        for (int b = 0; b < n; b++) begin
            int w;
            in_valid = 1'b1;
            in_data  = (b == 2) ? {x_hi, x_hi, x, x} : {x, x, x, x};
            w = 0;
            while (!if_a.in_ready && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) check("in_ready_timeout", 16'(if_a.in_ready), 16'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic run_vector(input string tag, input logic [15:0] x, input logic [15:0] x_hi,
                              input logic [15:0] er, input logic [15:0] en);
        send_beats(x, x_hi, 3);
        repeat (5) tick();
        check({tag, "_valid_early"}, 16'(if_a.out_valid), 16'd0);
        tick();
        check({tag, "_valid_a"}, 16'(if_a.out_valid), 16'd1);
        check({tag, "_valid_b"}, 16'(if_b.out_valid), 16'd1);
        check({tag, "_relu"}, if_a.out_data, er);
        check({tag, "_none"}, if_b.out_data, en);
        tick();
        check({tag, "_idle"}, 16'(busy_a), 16'd0);
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0200, 16'h0100, 16'h0100, 16'h0C00, 16'h0C00};
        vecs[1] = '{16'h0100, 16'h0200, 16'h0100, 16'h7FFF, 16'h0C00, 16'h0C00};
        vecs[2] = '{16'hFF00, 16'h0200, 16'h0100, 16'h0100, 16'h0000, 16'hF800};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[4] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h8000};
        vecs[5] = '{16'h0080, 16'hFF00, 16'h0300, 16'h0300, 16'h0E00, 16'h0E00};
        vecs[6] = '{16'h0100, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFF6};

        repeat (2) tick();
        check("rst_out_valid", 16'(if_a.out_valid), 16'd0);
        check("rst_out_data", if_a.out_data, 16'h0000);
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_cfg_ready", 16'(cfg_ready_a), 16'd1);
        check("rst_in_ready", 16'(if_a.in_ready), 16'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            load(vecs[i].wt, vecs[i].bias);
            run_vector($sformatf("vec%0d", i), vecs[i].x, vecs[i].x_hi,
                       vecs[i].exp_relu, vecs[i].exp_none);
        end

        // Output backpressure, with config writes and an input beat offered while busy.
        load(16'h0100, 16'h0200);
        out_ready = 1'b0;
        send_beats(16'h0100, 16'h0100, 3);
        repeat (6) tick();
        wt_valid   = 1'b1;
        wt_data    = 16'h0000;
        bias_valid = 1'b1;
        bias_data  = 16'h7FFF;
        in_valid   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("bp_valid", 16'(if_a.out_valid), 16'd1);
            check("bp_data", if_a.out_data, 16'h0C00);
            check("bp_in_ready", 16'(if_a.in_ready), 16'd0);
            check("bp_cfg_ready", 16'(cfg_ready_a), 16'd0);
            tick();
        end
        wt_valid   = 1'b0;
        bias_valid = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        tick();
        check("bp_release_idle", 16'(busy_a), 16'd0);
        run_vector("bp_second", 16'h0100, 16'h0100, 16'h0C00, 16'h0C00);

        // Reset mid-vector, then mismatched config writes.
        send_beats(16'h0100, 16'h0100, 2);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 16'(if_a.out_valid), 16'd0);
        check("abort_busy", 16'(busy_a), 16'd0);
        check("abort_in_ready", 16'(if_a.in_ready), 16'd1);
        tick();
        rst_n = 1'b1;
        tick();
        cfg_neuron = 16'd1;
        load(16'hFF00, 16'h7FFF);
        cfg_neuron = 16'd0;
        cfg_layer  = 16'd3;
        load(16'hFF00, 16'h7FFF);
        cfg_layer  = 16'd0;
        // Weights survive reset, bias was cleared by it.
        run_vector("post_reset", 16'h0100, 16'h0100, 16'h0A00, 16'h0A00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
